// File: rtl/scan_pkg.sv
// Shared types and frame-geometry defaults for the scan memory arbiter.
// Optional capture-stall statistics are enabled with SCAN_ARB_STATS_EN.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAP,
    ST_FETCH,
    ST_DRAIN
  } arb_state_t;

  localparam int V_VISIBLE_D = 768;
  localparam int V_TOTAL_D   = 807;
  localparam int DISP_BASE_D = 0;

endpackage

// File: rtl/scan_edge_det.sv
// Rising-edge detector for the horizontal blanking strobe.
// Compares the live input against a one-cycle registered copy.
module scan_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/scan_mem_arbiter.sv
// Sample RAM arbiter: blanking-time line prefetch vs capture writes.
// Define SCAN_ARB_STATS_EN to enable the capture stall counter.
module scan_mem_arbiter
  import scan_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 4,
  parameter int FETCH_WORDS = 256,
  parameter int V_VISIBLE   = V_VISIBLE_D,
  parameter int V_TOTAL     = V_TOTAL_D,
  parameter int DISP_BASE   = DISP_BASE_D,
  localparam int LB_W =
    (FETCH_WORDS > 1) ? $clog2(FETCH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        line_in,
  input  logic              h_blank,
  input  logic              cap_req,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  output logic              cap_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [LB_W-1:0]   lb_addr,
  output logic [DATA_W-1:0] lb_data,
  output logic              fetch_ovf,
  output logic [15:0]       cap_stall_cnt
);

  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LB_W-1:0]   r_cnt;
  logic              r_pend;
  logic              r_ovf;
  logic              r_lb_we;
  logic [LB_W-1:0]   r_lb_addr;

  logic w_rise;
  logic w_trig;
  logic w_wrap;
  logic w_busy;
  logic w_last;
  logic w_fetch;

  scan_edge_det u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (h_blank),
    .o_rise (w_rise)
  );

  assign w_wrap  = (line_in == 10'(V_TOTAL - 1));
  assign w_trig  = w_rise &&
                   ((line_in < 10'(V_VISIBLE - 1)) || w_wrap);
  assign w_fetch = (r_state == ST_FETCH);
  assign w_busy  = w_fetch || (r_state == ST_DRAIN);
  assign w_last  = (r_cnt == LB_W'(FETCH_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rd_ptr  <= ADDR_W'(DISP_BASE);
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_ovf     <= 1'b0;
      r_lb_we   <= 1'b0;
      r_lb_addr <= '0;
    end else begin
      r_lb_we   <= w_fetch;
      r_lb_addr <= w_fetch ? r_cnt : '0;
      if (w_trig && w_busy) begin
        r_ovf <= 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_trig || r_pend) begin
            r_state <= ST_FETCH;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
            if (w_trig && w_wrap) begin
              r_rd_ptr <= ADDR_W'(DISP_BASE);
            end
          end else if (cap_req) begin
            r_state <= ST_CAP;
          end
        end
        ST_CAP: begin
          r_state <= ST_IDLE;
          if (w_trig) begin
            r_pend <= 1'b1;
            if (w_wrap) begin
              r_rd_ptr <= ADDR_W'(DISP_BASE);
            end
          end
        end
        ST_FETCH: begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= ST_DRAIN;
          end
        end
        // Hand a waiting capture straight over so it waits FETCH_WORDS+2.
        ST_DRAIN: begin
          r_state <= cap_req ? ST_CAP : ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cap_gnt   = (r_state == ST_CAP);
  assign mem_en    = cap_gnt || w_fetch;
  assign mem_we    = cap_gnt;
  assign mem_addr  = cap_gnt ? cap_addr :
                     w_fetch ? r_rd_ptr : '0;
  assign mem_wdata = cap_gnt ? cap_data : '0;
  assign lb_we     = r_lb_we;
  assign lb_addr   = r_lb_addr;
  assign lb_data   = r_lb_we ? mem_rdata : '0;
  assign fetch_ovf = r_ovf;

`ifdef SCAN_ARB_STATS_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (cap_req && !cap_gnt &&
                 (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign cap_stall_cnt = r_stall;
`else
  assign cap_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_scan_mem_arbiter.sv
// Directed/randomized bench for scan_mem_arbiter with a RAM image model.
// Stall counter expectations follow SCAN_ARB_STATS_EN.
module tb_scan_mem_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 4;
  localparam int FW   = 4;
  localparam int VV   = 768;
  localparam int VT   = 807;
  localparam int BASE = 4094;
  localparam int LBW  = 2;
  localparam int MSZ  = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    line_in = '0;
  logic          h_blank = 1'b0;
  logic          cap_req = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic [DW-1:0] cap_data = '0;
  logic          cap_gnt;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          lb_we;
  logic [LBW-1:0] lb_addr;
  logic [DW-1:0] lb_data;
  logic          fetch_ovf;
  logic [15:0]   cap_stall_cnt;

  logic [DW-1:0] ram [MSZ];
  logic [DW-1:0] ref_ram [MSZ];
  int ptr_m;
  int exp_stall;
  int n_checks;
  int n_fail;

  scan_mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .FETCH_WORDS (FW),
    .V_VISIBLE   (VV),
    .V_TOTAL     (VT),
    .DISP_BASE   (BASE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_in       (line_in),
    .h_blank       (h_blank),
    .cap_req       (cap_req),
    .cap_addr      (cap_addr),
    .cap_data      (cap_data),
    .cap_gnt       (cap_gnt),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .lb_we         (lb_we),
    .lb_addr       (lb_addr),
    .lb_data       (lb_data),
    .fetch_ovf     (fetch_ovf),
    .cap_stall_cnt (cap_stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MSZ; i++) ram[i] <= ref_ram[i];
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_mem_en"}, 32'(mem_en), 0);
    chk({tag, "_lb_we"}, 32'(lb_we), 0);
    chk({tag, "_gnt"}, 32'(cap_gnt), 0);
  endtask

  task automatic idle(input int n);
    h_blank = 1'b0;
    cap_req = 1'b0;
    repeat (n) begin
      nxt;
      quiet("idle");
    end
  endtask

  task automatic capture(input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    cap_req  = 1'b1;
    cap_addr = a;
    cap_data = d;
    nxt;
    chk("cap_gnt", 32'(cap_gnt), 1);
    chk("cap_en", 32'(mem_en), 1);
    chk("cap_we", 32'(mem_we), 1);
    chk("cap_addr", 32'(mem_addr), 32'(a));
    chk("cap_wdata", 32'(mem_wdata), 32'(d));
    ref_ram[a] = d;
    exp_stall++;
    cap_req = 1'b0;
  endtask

  task automatic do_fetch(input int line, input int lead,
                          input bit with_cap, input bit ovf_mid);
    int base;
    base = (line == VT - 1) ? BASE : ptr_m;
    h_blank = 1'b1;
    line_in = 10'(line);
    for (int d = 1; d < lead; d++) begin
      nxt;
      chk("pend_wait_en", 32'(mem_en), 0);
    end
    for (int k = 0; k <= FW; k++) begin
      nxt;
      chk($sformatf("f%0d_gnt", k), 32'(cap_gnt), 0);
      if (k < FW) begin
        chk($sformatf("f%0d_en", k), 32'(mem_en), 1);
        chk($sformatf("f%0d_we", k), 32'(mem_we), 0);
        chk($sformatf("f%0d_addr", k), 32'(mem_addr),
            32'((base + k) % MSZ));
      end else begin
        chk("drain_en", 32'(mem_en), 0);
      end
      if (k > 0) begin
        chk($sformatf("lb%0d_we", k), 32'(lb_we), 1);
        chk($sformatf("lb%0d_addr", k), 32'(lb_addr), k - 1);
        chk($sformatf("lb%0d_data", k), 32'(lb_data),
            32'(ref_ram[(base + k - 1) % MSZ]));
      end else begin
        chk("lb_first_we", 32'(lb_we), 0);
      end
      if (ovf_mid && k == 1) h_blank = 1'b0;
      if (ovf_mid && k == 2) h_blank = 1'b1;
    end
    nxt;
    chk("post_lb_we", 32'(lb_we), 0);
    if (with_cap) begin
      chk("late_gnt", 32'(cap_gnt), 1);
      chk("late_addr", 32'(mem_addr), 32'(cap_addr));
      chk("late_wdata", 32'(mem_wdata), 32'(cap_data));
      ref_ram[cap_addr] = cap_data;
      exp_stall += FW + 2;
      cap_req = 1'b0;
    end else begin
      chk("post_gnt", 32'(cap_gnt), 0);
    end
    ptr_m = (base + FW) % MSZ;
  endtask

  task automatic reset_outs(input string tag);
    chk({tag, "_en"}, 32'(mem_en), 0);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_gnt"}, 32'(cap_gnt), 0);
    chk({tag, "_lb_we"}, 32'(lb_we), 0);
    chk({tag, "_lb_addr"}, 32'(lb_addr), 0);
    chk({tag, "_lb_data"}, 32'(lb_data), 0);
    chk({tag, "_ovf"}, 32'(fetch_ovf), 0);
    chk({tag, "_stall"}, 32'(cap_stall_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_stall = 0;
    ptr_m     = BASE;
    for (int i = 0; i < MSZ; i++) ref_ram[i] = DW'($urandom);

    #12;
    reset_outs("rst");
    nxt;
    rst_n = 1'b1;
    idle(2);

    do_fetch(5, 1, 1'b0, 1'b0);
    idle(2);

    capture(12'h123, 4'hA);
    idle(1);
    chk("gnt_one_cycle", 32'(cap_gnt), 0);
    for (int i = 0; i < 4; i++) begin
      capture(AW'($urandom), DW'($urandom));
      idle(1);
    end

    do_fetch(int'($urandom_range(VV - 2, 0)), 1, 1'b0, 1'b0);
    idle(2);

    cap_req  = 1'b1;
    cap_addr = AW'($urandom);
    cap_data = DW'($urandom);
    do_fetch(int'($urandom_range(VV - 2, 0)), 1, 1'b1, 1'b0);
    idle(2);

    capture(AW'(ptr_m), DW'($urandom));
    do_fetch(int'($urandom_range(VV - 2, 0)), 2, 1'b0, 1'b0);
    idle(2);

    h_blank = 1'b1;
    line_in = 10'(VV - 1);
    repeat (4) begin
      nxt;
      quiet("no_fetch_767");
    end
    idle(1);
    h_blank = 1'b1;
    line_in = 10'($urandom_range(VT - 2, VV));
    repeat (4) begin
      nxt;
      quiet("no_fetch_vbl");
    end
    idle(1);

    do_fetch(VT - 1, 1, 1'b0, 1'b0);
    idle(2);

    chk("ovf_clear", 32'(fetch_ovf), 0);
    do_fetch(int'($urandom_range(VV - 2, 0)), 1, 1'b0, 1'b1);
    chk("ovf_set", 32'(fetch_ovf), 1);
    idle(3);
    capture(AW'($urandom), DW'($urandom));
    idle(1);
    chk("ovf_sticky", 32'(fetch_ovf), 1);
    do_fetch(int'($urandom_range(VV - 2, 0)), 1, 1'b0, 1'b0);
    idle(2);

`ifdef SCAN_ARB_STATS_EN
    chk("stall_cnt", 32'(cap_stall_cnt), 32'(exp_stall));
`else
    chk("stall_tied", 32'(cap_stall_cnt), 0);
`endif

    h_blank = 1'b1;
    line_in = 10'd10;
    nxt;
    nxt;
    chk("mid_fetch_en", 32'(mem_en), 1);
    rst_n = 1'b0;
    #1;
    reset_outs("midrst");
    h_blank = 1'b0;
    nxt;
    nxt;
    rst_n = 1'b1;
    ptr_m = BASE;
    exp_stall = 0;
    idle(2);
    do_fetch(20, 1, 1'b0, 1'b0);
    idle(2);
    chk("final_ovf", 32'(fetch_ovf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_mem_arbiter.md
# scan_mem_arbiter

Arbitrates the single-port sample RAM between the capture engine (writes) and the VGA display line prefetch (reads). During each horizontal blanking interval preceding a visible line, it bursts that line's sample words from RAM into the display line buffer. Capture writes are serviced in all remaining cycles. It sits between the capture path, the sample RAM, and the VGA line buffer, and is driven by the H/V timing counters.

## Interface
- ADDR_W, 12, sample RAM address width
- DATA_W, 4, sample word width (one bit per channel)
- FETCH_WORDS, 256, words fetched per display line; must be ≤ horizontal blanking width in clk cycles
- V_VISIBLE, 768, visible lines per frame
- V_TOTAL, 807, total line count (line_in range 0..V_TOTAL-1)
- DISP_BASE, 0, RAM address of first word of line 0
---
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- line_in  in  10  current line number from vertical counter
- h_blank  in  1  high during horizontal blanking
- cap_req  in  1  capture write request; held until cap_gnt
- cap_addr  in  ADDR_W  capture write address; stable while cap_req
- cap_data  in  DATA_W  capture write data; stable while cap_req
- cap_gnt  out  1  one-cycle grant; write issued this cycle
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after read issue
- lb_we  out  1  line buffer write strobe
- lb_addr  out  8  line buffer word index (clog2 FETCH_WORDS)
- lb_data  out  DATA_W  line buffer data
- fetch_ovf  out  1  sticky: fetch trigger arrived while fetch busy
- cap_stall_cnt  out  16  capture stall cycles (see Configuration)

## Operation
- States: IDLE, CAP, FETCH, DRAIN.
- Trigger: rising edge of h_blank (registered delay compare) with line_in < V_VISIBLE-1 or line_in == V_TOTAL-1; sets fetch_pend.
- Pointer rd_ptr: loaded with DISP_BASE when trigger occurs at line_in == V_TOTAL-1; otherwise continues from the previous fetch. Increments per read and wraps modulo 2^ADDR_W.
- IDLE: fetch_pend → FETCH (clears pend). Else cap_req → CAP. Fetch wins simultaneous events.
- CAP (1 cycle): mem_en=mem_we=1, mem_addr=cap_addr, mem_wdata=cap_data, cap_gnt=1 → IDLE.
- FETCH: one read per cycle (mem_en=1, mem_we=0, mem_addr=rd_ptr), FETCH_WORDS reads, then → DRAIN.
- DRAIN (1 cycle): last read data written to line buffer → IDLE.
- Line buffer: lb_we=1 in the cycle after each read issue, lb_data=mem_rdata, lb_addr=0..FETCH_WORDS-1 in order.
- Trigger while in FETCH/DRAIN: ignored, fetch_ovf set until reset. Trigger during CAP: latched in fetch_pend, serviced next IDLE cycle.
- cap_req is never granted in FETCH/DRAIN.

## Timing
- mem_* and cap_gnt are decoded from state and address registers; lb_* are registered.
- h_blank rises at cycle t (sampled at edge t+1): first read at t+1 if IDLE, first lb_we at t+2, last lb_we at t+1+FETCH_WORDS.
- Capture latency in IDLE: cap_req at cycle c → cap_gnt at c+1 (state CAP).
- Worst case capture wait: FETCH_WORDS+2 cycles.
- Reset: state IDLE, all outputs 0, rd_ptr=DISP_BASE, fetch_pend=0, fetch_ovf=0, cap_stall_cnt=0. Reset mid-fetch abandons the burst; no partial line completion.

## Configuration
- SCAN_ARB_STATS_EN defined: cap_stall_cnt counts cycles with cap_req=1 and cap_gnt=0, saturating at 0xFFFF, cleared only by reset.
- Not defined: counter logic is absent and cap_stall_cnt is tied to 0.

## Structure
- Shared package scan_pkg: arbiter state enum, V_VISIBLE/V_TOTAL defaults, DISP_BASE.
- One sub-module, scan_edge_det: h_blank rising-edge detector.
- Counters and the FSM stay in the top module.

## Test plan
- Trigger at line_in=5 (FETCH_WORDS=4 override) → reads at rd_ptr..+3, lb_we 4 cycles with lb_addr 0..3 one cycle after each read.
- cap_req held with cap_addr=0x123, cap_data=0xA in IDLE → cap_gnt one cycle later, mem_we=1, mem_addr=0x123, mem_wdata=0xA.
- cap_req and trigger in the same cycle → FETCH first; cap_gnt after DRAIN, exactly FETCH_WORDS+2 cycles later.
- Trigger at line_in=V_TOTAL-1 → first read address DISP_BASE. Trigger at line_in=V_VISIBLE-1 → no fetch.
- Second h_blank edge forced mid-FETCH → fetch_ovf=1 and stays 1; burst length unchanged.
- rst_n low mid-FETCH → all outputs 0 immediately; with SCAN_ARB_STATS_EN defined, stalled cap_req counts up and saturates at 0xFFFF.
